// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared constants for the instruction fetch stage and control unit
package ifetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

endpackage

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - small synchronous FIFO of {instruction word, pc} with flush
module ifetch_fifo #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [31:0]   push_data,
  input  logic [31:0]   push_pc,
  input  logic          pop,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [31:0]   head_data,
  output logic [31:0]   head_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = data_q[rd_ptr];
  assign head_pc   = pc_q[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      data_q[wr_ptr] <= push_data;
      pc_q[wr_ptr]   <= push_pc;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch stage: PC, imem request credit, response queue, redirect
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [5:0]  op,
  output logic [5:0]  funct
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   target_pc;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [CW+1:0] occupancy;
  logic          fifo_empty;
  logic          head_pop;
  logic          credit;
  logic          grant;
  logic          keep;
  logic          discard;
  logic          rsp_counted;
  logic          unused_ok;

  assign unused_ok = &{1'b0, redirect_pc[1:0]};
  assign target_pc = {redirect_pc[31:2], 2'b00};

  assign inst_valid = !fifo_empty && !rst;
  assign head_pop   = inst_valid && inst_ready;
  assign op         = inst[OP_MSB:OP_LSB];
  assign funct      = inst[FUNCT_MSB:FUNCT_LSB];

  // Words the queue may still have to hold: queued (minus any leaving now) plus all in flight.
  assign occupancy = (CW+2)'(count) + (CW+2)'(out_cnt) + (CW+2)'(drop_cnt) - (CW+2)'(head_pop);
  assign credit    = occupancy < (CW+2)'(DEPTH);
  assign imem_req  = credit && !redirect_valid && !rst;
  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;

  assign rsp_counted = imem_rvalid && ((drop_cnt != '0) || (out_cnt != '0));
  assign discard     = imem_rvalid && (drop_cnt != '0);
  assign keep        = imem_rvalid && (drop_cnt == '0) && (out_cnt != '0);

  // PC, expected response address and in-flight accounting; redirect overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      rsp_pc   <= RESET_PC;
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      pc       <= target_pc;
      rsp_pc   <= target_pc;
      out_cnt  <= '0;
      drop_cnt <= drop_cnt + out_cnt - CW'(rsp_counted);
    end else begin
      if (grant) pc <= pc + 32'd4;
      if (keep)  rsp_pc <= rsp_pc + 32'd4;
      out_cnt <= out_cnt + CW'(grant) - CW'(keep);
      if (discard) drop_cnt <= drop_cnt - 1'b1;
    end
  end

  ifetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (keep && !redirect_valid),
    .push_data (imem_rdata),
    .push_pc   (rsp_pc),
    .pop       (head_pop && !redirect_valid),
    .empty     (fifo_empty),
    .count     (count),
    .head_data (inst),
    .head_pc   (inst_pc)
  );

endmodule
